// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//  Shared types and constants for the 4-digit 7-segment scan driver.
//  Contents:
//   phase_t    : per-digit scan phase (PH_GAP = anodes off, PH_ON = digit lit)
//   SEG_BLANK  : all segments off (active-low)
//   SEG_DASH   : only segment g on, used when the time counter has overflowed
//   SEG_DIGIT  : active-low {g,f,e,d,c,b,a} patterns for BCD 0..9
// -----------------------------------------------------------------------------
package display_pkg;

   typedef enum logic {
      PH_GAP = 1'b0,
      PH_ON  = 1'b1
   } phase_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Index 0 first: SEG_DIGIT[n] is the pattern for decimal digit n.
   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000    // 9
   };

   // One-hot active-low anode pattern for a digit position (0 = rightmost).
   function automatic logic [3:0] anode_for(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
//  Combinational BCD to active-low 7-segment decoder. Codes 10..15 are not
//  valid BCD and are shown dark rather than as hex glyphs.
//  Ports:
//   bcd  in  4  BCD digit
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_to_seg7
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (bcd < 4'd10) begin
         seg = SEG_DIGIT[bcd];
      end
   end

endmodule

// File: rtl/bcd_display_scan.sv
// -----------------------------------------------------------------------------
// bcd_display_scan
//  Time-multiplexed driver for a 4-digit common-anode 7-segment display fed by
//  the reaction-timer BCD digit bus. Digit 3 is leftmost, so the display reads
//  "S.mmm". Each digit gets one dark anti-ghost cycle followed by DWELL_CYCLES
//  lit cycles; the digit values are snapshotted once per frame (at the end of
//  digit 0's gap cycle) so one scan never mixes two counter values.
//  All pins are registered: they reflect the scan state one cycle earlier.
//
//  Optional build macro DIM_EN: adds input `dim`; when high, each digit is lit
//  only for the first DWELL_CYCLES/2 cycles of its ON phase. Frame timing is
//  unchanged.
//
//  Parameters:
//   DWELL_CYCLES  lit cycles per digit per frame (>= 2, even if DIM_EN used)
//  Ports:
//   clk        in   1  system clock
//   rst        in   1  reset, asynchronous, active-low
//   d3..d0     in   4  BCD digits (d3 = seconds, d0 = milliseconds)
//   time_late  in   1  counter overflow; whole frame shows dashes
//   blank      in   1  force display dark (scan keeps running)
//   dim        in   1  half-brightness request (DIM_EN builds only)
//   an         out  4  digit anodes, active-low, an[3] = leftmost
//   seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  1  decimal point, active-low
// -----------------------------------------------------------------------------
module bcd_display_scan
   import display_pkg::*;
#(
   parameter int DWELL_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   input  logic       time_late,
   input  logic       blank,
`ifdef DIM_EN
   input  logic       dim,
`endif
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
`ifdef DIM_EN
   localparam logic [DWELL_W-1:0] DWELL_HALF = DWELL_W'(DWELL_CYCLES / 2);
`endif

   // ---------------------------------------------------------------------
   // Scan state
   // ---------------------------------------------------------------------
   phase_t             phase_reg, phase_next;
   logic [1:0]         idx_reg, idx_next;
   logic [DWELL_W-1:0] dwell_reg, dwell_next;

   // Frame snapshot of the digit bus
   logic [3:0]         din [4];
   logic [3:0]         snap_digit_reg [4];
   logic               snap_late_reg;
   logic               capture;

   // Registered pins
   logic [3:0]         an_reg, an_next;
   logic [6:0]         seg_reg, seg_next;
   logic               dp_reg, dp_next;

   logic [3:0]         cur_digit;
   logic [6:0]         dec_seg;
   logic               dim_dark;
   logic               lit;

   assign din[0] = d0;
   assign din[1] = d1;
   assign din[2] = d2;
   assign din[3] = d3;

   // The snapshot is taken on the edge that ends digit 0's gap cycle, so the
   // first lit cycle of the frame already sees the new values.
   assign capture = (phase_reg == PH_GAP) && (idx_reg == 2'd0);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_snap
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               snap_digit_reg[gi] <= 4'd0;
            end else if (capture) begin
               snap_digit_reg[gi] <= din[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_late_reg <= 1'b0;
      end else if (capture) begin
         snap_late_reg <= time_late;
      end
   end

   // ---------------------------------------------------------------------
   // Digit decode on the currently scanned snapshot digit
   // ---------------------------------------------------------------------
   assign cur_digit = snap_digit_reg[idx_reg];

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

`ifdef DIM_EN
   // Dimming keeps the slot timing and just darkens the back half of ON.
   assign dim_dark = dim && (dwell_reg >= DWELL_HALF);
`else
   assign dim_dark = 1'b0;
`endif

   assign lit = (phase_reg == PH_ON) && !blank && !dim_dark;

   // ---------------------------------------------------------------------
   // Next-state and next-pin logic
   // ---------------------------------------------------------------------
   always_comb begin
      phase_next = phase_reg;
      idx_next   = idx_reg;
      dwell_next = dwell_reg;
      an_next    = 4'b1111;
      seg_next   = SEG_BLANK;
      dp_next    = 1'b1;

      case (phase_reg)
         PH_GAP: begin
            phase_next = PH_ON;
            dwell_next = '0;
         end
         PH_ON: begin
            if (dwell_reg == DWELL_LAST) begin
               dwell_next = '0;
               phase_next = PH_GAP;
               idx_next   = idx_reg + 2'd1;   // 3 wraps to 0 naturally
            end else begin
               dwell_next = dwell_reg + 1'b1;
            end
         end
         default: begin
            phase_next = PH_GAP;
         end
      endcase

      if (lit) begin
         an_next  = anode_for(idx_reg);
         seg_next = snap_late_reg ? SEG_DASH : dec_seg;
         // Decimal point sits after the seconds digit, hidden on overflow.
         dp_next  = !((idx_reg == 2'd3) && !snap_late_reg);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_reg <= PH_GAP;
         idx_reg   <= 2'd0;
         dwell_reg <= '0;
         an_reg    <= 4'b1111;
         seg_reg   <= SEG_BLANK;
         dp_reg    <= 1'b1;
      end else begin
         phase_reg <= phase_next;
         idx_reg   <= idx_next;
         dwell_reg <= dwell_next;
         an_reg    <= an_next;
         seg_reg   <= seg_next;
         dp_reg    <= dp_next;
      end
   end

   assign an  = an_reg;
   assign seg = seg_reg;
   assign dp  = dp_reg;

endmodule

// File: tb/tb_bcd_display_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scan
//  Scoreboard bench: the stimulus process pushes the expected pin values for
//  every sampled cycle of a frame into a queue; a monitor on the falling edge
//  pops one entry per cycle and compares it with the pins.
// -----------------------------------------------------------------------------
module tb_bcd_display_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
   logic       time_late = 1'b0;
   logic       blank = 1'b0;
`ifdef DIM_EN
   logic       dim = 1'b0;
`endif
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int checks   = 0;
   int failures = 0;
   logic mon_en = 1'b0;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      int         tag;
   } exp_t;

   exp_t exp_q [$];

   // Hand-written active-low patterns, {g,f,e,d,c,b,a}
   logic [6:0] seg_tbl [16];
   initial begin
      seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
      seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
      seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
      seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
      seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
      for (int i = 10; i < 16; i++) seg_tbl[i] = 7'h7F;
   end

   bcd_display_scan #(.DWELL_CYCLES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .d3        (d3),
      .d2        (d2),
      .d1        (d1),
      .d0        (d0),
      .time_late (time_late),
      .blank     (blank),
`ifdef DIM_EN
      .dim       (dim),
`endif
      .an        (an),
      .seg       (seg),
      .dp        (dp)
   );

   always #5 clk = ~clk;

   // Monitor: one comparison per sampled cycle
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scan_underflow an=%b seg=%b dp=%b required=queued entry", an, seg, dp);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
               failures++;
               $display("FAIL scan tag=%0d an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                        e.tag, an, seg, dp, e.an, e.seg, e.dp);
            end else begin
               $display("ok   scan tag=%0d an=%b seg=%b dp=%b", e.tag, an, seg, dp);
            end
         end
      end
   end

   task automatic push_exp(input logic [3:0] a, input logic [6:0] s, input logic p, input int tag);
      exp_t e;
      e.an = a; e.seg = s; e.dp = p; e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Expected 12 samples of one frame: lit0,lit0,gap,lit1,lit1,gap,...,lit3,lit3,gap.
   // Blank set during iteration j darkens sample j-1.
   task automatic push_frame(input logic [15:0] dig, input logic late,
                             input logic [12:0] bmask, input int test_id, input int count);
      for (int e = 0; e < count; e++) begin
         int i;
         logic [3:0] nib;
         i = e / 3;
         nib = dig[i*4 +: 4];
         if ((e % 3) == 2 || bmask[e+1])
            push_exp(4'b1111, 7'h7F, 1'b1, test_id*100 + e);
         else
            push_exp(~(4'b0001 << i), late ? 7'b0111111 : seg_tbl[nib],
                     (i == 3 && !late) ? 1'b0 : 1'b1, test_id*100 + e);
      end
   endtask

   // Called just after a falling edge that precedes a snapshot edge.
   // dig packs {d3,d2,d1,d0}.
   task automatic run_frame(input logic [15:0] dig, input logic late, input logic [12:0] bmask,
                            input logic mid_en, input logic [3:0] mid_d0, input int test_id);
      {d3, d2, d1, d0} = dig;
      time_late = late;
      push_frame(dig, late, bmask, test_id, 12);
      for (int j = 0; j < 12; j++) begin
         blank = bmask[j];
         if (mid_en && j == 5) d0 = mid_d0;
         @(negedge clk); #1;
      end
      blank = 1'b0;
   endtask

   task automatic check_pins(input string name, input logic [3:0] a, input logic [6:0] s, input logic p);
      checks++;
      if ({an, seg, dp} !== {a, s, p}) begin
         failures++;
         $display("FAIL %s an=%b seg=%b dp=%b required an=%b seg=%b dp=%b", name, an, seg, dp, a, s, p);
      end else begin
         $display("ok   %s an=%b seg=%b dp=%b", name, an, seg, dp);
      end
   endtask

   // Release reset between edges; the next rising edge ends digit 0's gap.
   task automatic release_reset(input int test_id);
      @(negedge clk); #2;
      rst = 1'b1;
      mon_en = 1'b1;
      push_exp(4'b1111, 7'h7F, 1'b1, test_id*100 + 99);   // state still PH_GAP
   endtask

   initial begin
      // ---- Test 1: reset state, then a plain frame of 1.234
      {d3, d2, d1, d0} = 16'h1234;
      repeat (3) @(negedge clk);
      #1;
      check_pins("reset_state", 4'b1111, 7'h7F, 1'b1);
      release_reset(1);
      run_frame(16'h1234, 1'b0, 13'h0, 1'b0, 4'd0, 1);

      // ---- Test 2: d0 changes mid-frame; visible only next frame
      run_frame(16'h1234, 1'b0, 13'h0, 1'b1, 4'd7, 2);
      run_frame(16'h1237, 1'b0, 13'h0, 1'b0, 4'd0, 21);

      // ---- Test 3: overflow frame shows dashes, no decimal point
      run_frame(16'h1237, 1'b1, 13'h0, 1'b0, 4'd0, 3);

      // ---- Test 4: blank for 5 cycles mid-frame, then undisturbed scan
      run_frame(16'h1237, 1'b0, 13'b0000011111000, 1'b0, 4'd0, 4);
      run_frame(16'h1237, 1'b0, 13'h0, 1'b0, 4'd0, 41);

      // ---- Test 5: invalid BCD on digit 1 -> dark segments, anode still on
      run_frame(16'h12C7, 1'b0, 13'h0, 1'b0, 4'd0, 5);

      // ---- Test 6: async reset during digit 1's ON phase
      {d3, d2, d1, d0} = 16'h12C7;
      push_frame(16'h12C7, 1'b0, 13'h0, 6, 4);
      repeat (5) begin @(negedge clk); #1; end
      mon_en = 1'b0;
      check_pins("pre_reset_lit", 4'b1101, 7'h7F, 1'b1);
      #2 rst = 1'b0;
      #1;
      check_pins("async_reset_dark", 4'b1111, 7'h7F, 1'b1);
      if (exp_q.size() != 0) exp_q.delete();
      {d3, d2, d1, d0} = 16'h9865;
      repeat (2) @(negedge clk);
      release_reset(7);
      run_frame(16'h9865, 1'b0, 13'h0, 1'b0, 4'd0, 7);
      run_frame(16'h0000, 1'b0, 13'h0, 1'b0, 4'd0, 8);

      // Drain the last gap sample, bounded
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      mon_en = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d required=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
